// File: rtl/sigmoid_pkg.sv
// rtl/sigmoid_pkg.sv - shared fixed-point types and FSM state encoding for the sigmoid sequencer
// Purpose : 4.8 fixed-point widths, the fx_t word type and the controller state enum.
// Ports   : none (package).
package sigmoid_pkg;

   localparam int          FX_W   = 12;
   localparam int          FRAC_W = 8;
   localparam logic [11:0] FX_ONE = 12'h100;

   typedef logic [FX_W-1:0] fx_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      RESULT = 2'd2
   } sig_state_t;

endpackage

// File: rtl/sigmoid_sym_fold.sv
// rtl/sigmoid_sym_fold.sv - symmetry fold/unfold helpers around the positive-only sigmoid core
// Purpose : fold a signed operand onto the positive axis and unfold the core result
//           with sig(-x) = 1 - sig(x).
// Ports   : in_x     - signed 4.8 operand
//           sign_q   - registered sign of the operand in flight
//           raw_fx   - raw core result
//           sign     - sign bit of in_x
//           mag      - |in_x|, clamped to 0x7FF for the most negative input
//           unfolded - clamped core result, mirrored when sign_q is set
module sigmoid_sym_fold
   import sigmoid_pkg::*;
(
   input  fx_t  in_x,
   input  logic sign_q,
   input  fx_t  raw_fx,
   output logic sign,
   output fx_t  mag,
   output fx_t  unfolded
);

   // -0x800 does not fit in 12 bits, so the most negative operand is pinned to 0x7FF.
   function automatic fx_t fold_mag(input fx_t x);
      if (!x[FX_W-1]) begin
         return x;
      end else if (x == 12'h800) begin
         return 12'h7FF;
      end else begin
         return fx_t'(-x);
      end
   endfunction

   // Clamping to 1.0 first guarantees FX_ONE - c cannot wrap.
   function automatic fx_t unfold(input fx_t raw, input logic s);
      fx_t c;
      c = (raw > FX_ONE) ? FX_ONE : raw;
      return s ? fx_t'(FX_ONE - c) : c;
   endfunction

   assign sign     = in_x[FX_W-1];
   assign mag      = fold_mag(in_x);
   assign unfolded = unfold(raw_fx, sign_q);

endmodule

// File: rtl/sigmoid_seq_ctrl.sv
// rtl/sigmoid_seq_ctrl.sv - valid/ready sequencer wrapping the fixed-latency sigmoid_taylor core
// Purpose : accept signed 4.8 operands, drive the folded magnitude to the core, wait
//           CORE_LAT cycles, unfold the sampled result and present it downstream.
//           Operands with magnitude >= SAT_THRESH bypass the core.
// Ports   : clk, reset            - clock, synchronous active-high reset
//           in_valid/in_ready/in_x   - operand stream (signed 4.8)
//           out_valid/out_ready/out_fx - result stream (unsigned 4.8, 0x000..0x100)
//           core_x / core_fx      - magnitude to the core / core result
//           busy                  - controller not idle
//           sat_count             - saturating count of bypassed operands
module sigmoid_seq_ctrl
   import sigmoid_pkg::*;
#(
   parameter int          CORE_LAT   = 2,
   parameter logic [11:0] SAT_THRESH = 12'h600,
   parameter logic [11:0] SAT_HI     = 12'h0FF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] in_x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] out_fx,
   output logic [11:0] core_x,
   input  logic [11:0] core_fx,
   output logic        busy,
   output logic [15:0] sat_count
);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_WAIT   = WAIT;
   localparam logic [1:0] ST_RESULT = RESULT;

   // Counter is loaded with CORE_LAT-1 so that sampling happens after exactly CORE_LAT cycles.
   localparam logic [3:0] LAT_M1    = 4'(CORE_LAT - 1);
   localparam fx_t        SAT_LO    = fx_t'(FX_ONE - SAT_HI);

   logic [1:0]  r_state;
   logic        r_sign;
   logic [3:0]  r_cnt;
   fx_t         r_out_fx;
   fx_t         r_core_x;
   logic [15:0] r_sat_count;

   logic        w_sign;
   fx_t         w_mag;
   fx_t         w_unfolded;
   logic        w_accept;

   sigmoid_sym_fold u_fold (
      .in_x     (in_x),
      .sign_q   (r_sign),
      .raw_fx   (core_fx),
      .sign     (w_sign),
      .mag      (w_mag),
      .unfolded (w_unfolded)
   );

   assign w_accept = in_valid && (r_state == ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_sign      <= 1'b0;
         r_cnt       <= 4'd0;
         r_out_fx    <= '0;
         r_core_x    <= '0;
         r_sat_count <= 16'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_sign <= w_sign;
                  if (w_mag >= SAT_THRESH) begin
                     // Bypass leaves core_x untouched so the core input does not toggle needlessly.
                     r_out_fx <= w_sign ? SAT_LO : SAT_HI;
                     if (r_sat_count != 16'hFFFF) begin
                        r_sat_count <= r_sat_count + 16'd1;
                     end
                     r_state <= ST_RESULT;
                  end else begin
                     r_core_x <= w_mag;
                     r_cnt    <= LAT_M1;
                     r_state  <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_out_fx <= w_unfolded;
                  r_state  <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_RESULT);
   assign busy      = (r_state != ST_IDLE);
   assign out_fx    = r_out_fx;
   assign core_x    = r_core_x;
   assign sat_count = r_sat_count;

endmodule

// File: tb/tb_sigmoid_seq_ctrl.sv
// tb/tb_sigmoid_seq_ctrl.sv - directed self-checking bench for sigmoid_seq_ctrl
module tb_sigmoid_seq_ctrl;

   localparam int CORE_LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_x;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_fx;
   logic [11:0] core_x;
   logic [11:0] core_fx;
   logic        busy;
   logic [15:0] sat_count;

   int errors = 0;
   int checks = 0;

   sigmoid_seq_ctrl #(
      .CORE_LAT   (CORE_LAT),
      .SAT_THRESH (12'h600),
      .SAT_HI     (12'h0FF)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_fx    (out_fx),
      .core_x    (core_x),
      .core_fx   (core_fx),
      .busy      (busy),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   // Stand-in for sigmoid_taylor: a few hand-picked points, 0x080 elsewhere.
   always_comb begin
      case (core_x)
         12'h280: core_fx = 12'h0EC;
         12'h300: core_fx = 12'h0F4;
         12'h100: core_fx = 12'h105;
         default: core_fx = 12'h080;
      endcase
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_timeout: in_ready=%b required 1", in_ready);
      end
      checks++;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_x      = 12'h000;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      checks++;
      if (out_fx !== 12'h000) begin errors++; $display("FAIL reset_out_fx: got %h required 000", out_fx); end
      checks++;
      if (core_x !== 12'h000) begin errors++; $display("FAIL reset_core_x: got %h required 000", core_x); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++;
      if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_sat_count: got %0d required 0", sat_count); end
      checks++;
   endtask

   task automatic test_core_path(input logic [11:0] x, input logic [11:0] exp_cx,
                                 input logic [11:0] exp_fx);
      wait_idle();
      in_valid = 1'b1;
      in_x     = x;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < CORE_LAT; k++) begin
         if (core_x !== exp_cx) begin
            errors++; $display("FAIL core_x_hold x=%h k=%0d: got %h required %h", x, k, core_x, exp_cx);
         end
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL core_wait x=%h k=%0d: out_valid=%b busy=%b required 0/1", x, k, out_valid, busy);
         end
         checks++;
         @(negedge clk);
      end
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL core_latency x=%h: out_valid=%b required 1", x, out_valid);
      end
      checks++;
      if (out_fx !== exp_fx) begin
         errors++; $display("FAIL core_result x=%h: out_fx=%h required %h", x, out_fx, exp_fx);
      end
      checks++;
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL core_release x=%h: out_valid=%b in_ready=%b required 0/1", x, out_valid, in_ready);
      end
      checks++;
   endtask

   task automatic test_bypass(input logic [11:0] x, input logic [11:0] exp_fx,
                              input logic [15:0] exp_sat, input logic [11:0] exp_cx);
      wait_idle();
      in_valid = 1'b1;
      in_x     = x;
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL bypass_latency x=%h: out_valid=%b required 1", x, out_valid);
      end
      checks++;
      if (out_fx !== exp_fx) begin
         errors++; $display("FAIL bypass_result x=%h: out_fx=%h required %h", x, out_fx, exp_fx);
      end
      checks++;
      if (sat_count !== exp_sat) begin
         errors++; $display("FAIL bypass_sat_count x=%h: got %0d required %0d", x, sat_count, exp_sat);
      end
      checks++;
      if (core_x !== exp_cx) begin
         errors++; $display("FAIL bypass_core_x x=%h: got %h required %h", x, core_x, exp_cx);
      end
      checks++;
   endtask

   task automatic test_backpressure();
      wait_idle();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_x      = 12'h280;
      @(negedge clk);
      in_x = 12'h100;  // held by the producer, must be ignored while busy
      repeat (CORE_LAT) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         if (out_valid !== 1'b1 || out_fx !== 12'h0EC) begin
            errors++; $display("FAIL bp_hold k=%0d: out_valid=%b out_fx=%h required 1/0ec", k, out_valid, out_fx);
         end
         checks++;
         if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL bp_busy k=%0d: in_ready=%b busy=%b required 0/1", k, in_ready, busy);
         end
         checks++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release: busy=%b in_ready=%b out_valid=%b required 0/1/0", busy, in_ready, out_valid);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      logic seen;
      wait_idle();
      in_valid = 1'b1;
      in_x     = 12'h280;
      @(negedge clk);
      in_valid = 1'b0;
      if (busy !== 1'b1 || core_x !== 12'h280) begin
         errors++; $display("FAIL rst_mid_pre: busy=%b core_x=%h required 1/280", busy, core_x);
      end
      checks++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_mid_state: in_ready=%b busy=%b out_valid=%b required 1/0/0", in_ready, busy, out_valid);
      end
      checks++;
      if (core_x !== 12'h000 || sat_count !== 16'd0) begin
         errors++; $display("FAIL rst_mid_regs: core_x=%h sat_count=%0d required 000/0", core_x, sat_count);
      end
      checks++;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      if (seen !== 1'b0) begin
         errors++; $display("FAIL rst_mid_no_result: out_valid seen=%b required 0", seen);
      end
      checks++;
   endtask

   task automatic test_back_to_back();
      wait_idle();
      in_valid = 1'b1;
      in_x     = 12'h800;
      @(negedge clk);
      if (out_valid !== 1'b1 || out_fx !== 12'h001 || in_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_first: out_valid=%b out_fx=%h in_ready=%b required 1/001/0", out_valid, out_fx, in_ready);
      end
      checks++;
      in_x = 12'h700;
      @(negedge clk);
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_gap: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
      checks++;
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || out_fx !== 12'h0FF || sat_count !== 16'd2) begin
         errors++; $display("FAIL b2b_second: out_valid=%b out_fx=%h sat_count=%0d required 1/0ff/2", out_valid, out_fx, sat_count);
      end
      checks++;
      @(negedge clk);
      if (busy !== 1'b0) begin
         errors++; $display("FAIL b2b_idle: busy=%b required 0", busy);
      end
      checks++;
   endtask

   initial begin
      test_reset();
      test_core_path(12'h280, 12'h280, 12'h0EC);
      test_core_path(12'hD00, 12'h300, 12'h00C);
      test_core_path(12'h100, 12'h100, 12'h100);
      test_core_path(12'hF00, 12'h100, 12'h000);
      test_core_path(12'h5FF, 12'h5FF, 12'h080);
      test_bypass(12'h800, 12'h001, 16'd1, 12'h5FF);
      test_bypass(12'h600, 12'h0FF, 16'd2, 12'h5FF);
      test_bypass(12'hA00, 12'h001, 16'd3, 12'h5FF);
      test_core_path(12'h000, 12'h000, 12'h080);
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
